vga_rect_scheduler: RTL and testbench
=====================================

# vga_rect_scheduler

Configurable overlay controller for the 1280x1024@60 VGA pipeline on `clk_108`. It holds a table of 8 colored rectangles written by a host through a valid/ready port. It commits the table atomically at the start of vertical blanking so no frame tears. Per pixel, it resolves the `red`/`green`/`blue` bits from the current horizontal/vertical counters of the timing generator.

## Interface
Parameters:
- `N_RECT`, 8: table entries; index width is 3, fixed.
- `CW`, 13: coordinate width, matching the 13-bit H/V counters.
- `H_ACTIVE`, 1280: visible pixels per line.
- `V_ACTIVE`, 1024: visible lines per frame.

Ports:
- `clk_108` in 1: pixel clock, 108 MHz.
- `rst_n` in 1: reset, synchronous, active-low.
- `pix_h` in CW: timing-generator horizontal counter, range 0..1687.
- `pix_v` in CW: timing-generator vertical counter, range 0..1065.
- `cfg_valid` in 1: host write request.
- `cfg_ready` out 1: shadow table accepts writes.
- `cfg_idx` in 3: entry to write.
- `cfg_x0`, `cfg_x1`, `cfg_y0`, `cfg_y1` in CW each: half-open bounds [x0,x1) x [y0,y1).
- `cfg_rgb` in 3: color {r,g,b}.
- `cfg_en` in 1: entry enable.
- `commit_req` in 1: request shadow→active copy at next vblank.
- `commit_busy` out 1: commit pending or in progress.
- `commit_done` out 1: one-cycle pulse when the active table has been updated.
- `red`, `green`, `blue` out 1 each: pixel color.

## Operation
- Two banks of N_RECT entries, each {en, x0, x1, y0, y1, rgb}:
  - shadow bank: written by the host.
  - active bank: drives the pixels.
- Write: when `cfg_valid && cfg_ready` is true on a clock edge, `shadow[cfg_idx]` takes all cfg fields. There is no write when `cfg_ready` = 0; `cfg_valid` may stay high until accepted.
- FSM states and transitions:
  - IDLE → PENDING: on `commit_req`.
  - PENDING → COPY: on the vblank-start cycle, `pix_v == V_ACTIVE && pix_h == 0`.
  - COPY: copies entry k (k = 0..7), one entry per cycle, over 8 cycles.
  - COPY → IDLE: after entry 7 is copied; `commit_done` pulses on the first IDLE cycle.
- `cfg_ready` = (state == IDLE).
- `commit_busy` = (state != IDLE).
- A `commit_req` outside IDLE is ignored, not queued.
- Same-cycle `commit_req` and an accepted write in IDLE: the write lands in shadow and is included in the commit.
- Pixel resolve, for visible pixels (`pix_h < H_ACTIVE && pix_v < V_ACTIVE`):
  - Entry i hits if `en_i && x0_i <= pix_h < x1_i && y0_i <= pix_v < y1_i`; comparisons are unsigned CW-bit.
  - The lowest-index hit wins, and its rgb is output.
  - If nothing hits, output 000.
  - Outside the visible area, output 000.
- An entry with `x0 >= x1` or `y0 >= y1` never hits.
- During COPY, pixels are blanked, so a mixed old/new table is never visible.

## Timing
- Reset values, held while `rst_n` = 0 at an edge:
  - FSM: IDLE.
  - Both banks: all fields 0, all entries disabled.
  - `red`, `green`, `blue`: 0.
  - `commit_done`: 0.
  - `commit_busy`: 0.
  - `cfg_ready`: 1, but writes are ignored while in reset.
- Pixel latency: `red`/`green`/`blue` are registered, 1 cycle after `pix_h`/`pix_v`. The timing generator's HS/VS are also registered, so color stays aligned with sync.
- Commit latency: from the vblank-start cycle, the active table is fully updated 8 cycles later. `commit_done` is asserted on cycle 9, which is well inside the 42-line blanking interval.
- Shadow is frozen from PENDING entry through the last COPY cycle.
- Reset asserted mid-PENDING or mid-COPY: the copy aborts, both banks clear, and the FSM returns to IDLE. No `commit_done` pulse is emitted.
- A vblank-start cycle seen while in IDLE has no effect.

## Test plan
- Reset, then write idx0 = {en=1, x0=100, x1=200, y0=50, y1=60, rgb=100} with no commit → `red`/`green`/`blue` stay 000 for the whole frame.
- Same write plus `commit_req` mid-frame at v=500:
  - `commit_busy` = 1 and `cfg_ready` = 0 until vblank.
  - `commit_done` pulses 9 cycles after (v=1024, h=0).
  - The next frame shows `red` = 1 exactly for h in 100..199 and v in 50..59, 1 cycle after the counter values.
- Overlap: idx2 = {0..400, 0..400, rgb=010} and idx5 = {0..400, 0..400, rgb=001} → output 010; after disabling idx2 and committing → output 001.
- Degenerate and boundary entries:
  - idx3 = {x0=300, x1=300} → never hits.
  - An entry with x1=1400 → no color at h ≥ 1280.
  - At pixel (h=1279, v=1023) → color present; at h=1280 → 000.
- Handshake:
  - `cfg_valid` held high during PENDING → not accepted until the first IDLE cycle, then written once.
  - A second `commit_req` during COPY → ignored; exactly one `commit_done`.
- Assert `rst_n` = 0 at COPY cycle 4 → no `commit_done`; afterwards all entries disabled and output 000 for the next frame.

Source files
------------

// File: rtl/vga_rect_scheduler_if.sv
// Host-side configuration and commit handshake for vga_rect_scheduler.
interface vga_rect_scheduler_if #(
    parameter int CW = 13
) ();
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_idx;
    logic [CW-1:0] cfg_x0;
    logic [CW-1:0] cfg_x1;
    logic [CW-1:0] cfg_y0;
    logic [CW-1:0] cfg_y1;
    logic [2:0]    cfg_rgb;
    logic          cfg_en;
    logic          commit_req;
    logic          commit_busy;
    logic          commit_done;

    modport master (
        output cfg_valid, cfg_idx, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_rgb, cfg_en, commit_req,
        input  cfg_ready, commit_busy, commit_done
    );

    modport slave (
        input  cfg_valid, cfg_idx, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_rgb, cfg_en, commit_req,
        output cfg_ready, commit_busy, commit_done
    );
endinterface

// File: rtl/vga_rect_scheduler.sv
// Rectangle overlay for 1280x1024@60: a double-buffered table of 8 rectangles,
// committed at vblank start and resolved to registered 1-bit RGB per pixel.
module vga_rect_scheduler #(
    parameter int N_RECT   = 8,
    parameter int CW       = 13,
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 1024
) (
    input  logic                clk_108,
    input  logic                rst_n,
    input  logic [CW-1:0]       pix_h,
    input  logic [CW-1:0]       pix_v,
    vga_rect_scheduler_if.slave cfg,
    output logic                red,
    output logic                green,
    output logic                blue
);
    typedef struct packed {
        logic          en;
        logic [CW-1:0] x0;
        logic [CW-1:0] x1;
        logic [CW-1:0] y0;
        logic [CW-1:0] y1;
        logic [2:0]    rgb;
    } rect_t;

    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_COPY} state_t;

    localparam logic [CW-1:0] H_LIM    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_LIM    = CW'(V_ACTIVE);
    localparam logic [2:0]    LAST_IDX = 3'(N_RECT - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_copy_idx;
    rect_t      r_shadow [N_RECT];
    rect_t      r_active [N_RECT];
    logic       r_commit_done;
    logic [2:0] r_rgb;

    logic       w_vblank_start;
    logic       w_cfg_fire;
    logic       w_copy_last;
    logic       w_visible;
    logic [2:0] w_hit_rgb;

    assign w_vblank_start = (pix_v == V_LIM) && (pix_h == '0);
    assign w_cfg_fire     = cfg.cfg_valid && cfg.cfg_ready;
    assign w_copy_last    = (r_state == S_COPY) && (r_copy_idx == LAST_IDX);
    assign w_visible      = (pix_h < H_LIM) && (pix_v < V_LIM);

    assign cfg.cfg_ready   = (r_state == S_IDLE);
    assign cfg.commit_busy = (r_state != S_IDLE);
    assign cfg.commit_done = r_commit_done;
    assign {red, green, blue} = r_rgb;

    always_comb begin
        // NOTE: default first so every path assigns w_state_next; a missing branch would infer a latch.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (cfg.commit_req) w_state_next = S_PENDING;
            S_PENDING: if (w_vblank_start) w_state_next = S_COPY;
            S_COPY:    if (w_copy_last)    w_state_next = S_IDLE;
            default:                       w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_108) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_copy_idx    <= '0;
            r_commit_done <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_copy_idx    <= (r_state == S_COPY) ? r_copy_idx + 3'd1 : 3'd0;
            r_commit_done <= w_copy_last;
        end
    end

    // NOTE: both banks are reset explicitly; a reset, even mid-copy, must leave every entry disabled.
    always_ff @(posedge clk_108) begin
        if (!rst_n) begin
            for (int i = 0; i < N_RECT; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            // Writes only land in IDLE, so shadow stays frozen across PENDING and COPY.
            if (w_cfg_fire) begin
                r_shadow[cfg.cfg_idx] <= '{en: cfg.cfg_en, x0: cfg.cfg_x0, x1: cfg.cfg_x1,
                                           y0: cfg.cfg_y0, y1: cfg.cfg_y1, rgb: cfg.cfg_rgb};
            end
            if (r_state == S_COPY) begin
                r_active[r_copy_idx] <= r_shadow[r_copy_idx];
            end
        end
    end

    // Scan from the highest index down so the lowest-index hit is the last one written.
    always_comb begin
        w_hit_rgb = 3'b000;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (r_active[i].en &&
                pix_h >= r_active[i].x0 && pix_h < r_active[i].x1 &&
                pix_v >= r_active[i].y0 && pix_v < r_active[i].y1) begin
                w_hit_rgb = r_active[i].rgb;
            end
        end
    end

    always_ff @(posedge clk_108) begin
        if (!rst_n) begin
            r_rgb <= 3'b000;
        end else begin
            r_rgb <= (w_visible && r_state != S_COPY) ? w_hit_rgb : 3'b000;
        end
    end
endmodule

// File: tb/tb_vga_rect_scheduler.sv
// Self-checking bench for vga_rect_scheduler: scoreboarded pixel expectations
// from a small rectangle-table model, plus commit/handshake/reset scenarios.
module tb_vga_rect_scheduler;
    localparam int CW = 13;

    typedef struct {
        bit       en;
        int       x0;
        int       x1;
        int       y0;
        int       y1;
        bit [2:0] rgb;
    } rect_t;

    logic          clk_108 = 1'b0;
    logic          rst_n   = 1'b0;
    logic [CW-1:0] pix_h   = '0;
    logic [CW-1:0] pix_v   = '0;
    logic          red, green, blue;

    vga_rect_scheduler_if #(.CW(CW)) cfg_if ();

    vga_rect_scheduler #(.N_RECT(8), .CW(CW), .H_ACTIVE(1280), .V_ACTIVE(1024)) dut (
        .clk_108 (clk_108),
        .rst_n   (rst_n),
        .pix_h   (pix_h),
        .pix_v   (pix_v),
        .cfg     (cfg_if),
        .red     (red),
        .green   (green),
        .blue    (blue)
    );

    always #5 clk_108 = ~clk_108;

    rect_t    m_shadow [8];
    rect_t    m_active [8];
    bit [2:0] exp_q [$];
    int       n_tests = 0;
    int       n_fail  = 0;

    // All stimulus changes and samples happen 1 ns after the rising edge.
    task automatic step();
        @(posedge clk_108);
        #1;
    endtask

    function automatic bit [2:0] model_rgb(input int h, input int v);
        if (h >= 1280 || v >= 1024) return 3'b000;
        for (int i = 0; i < 8; i++) begin
            if (m_active[i].en && h >= m_active[i].x0 && h < m_active[i].x1 &&
                v >= m_active[i].y0 && v < m_active[i].y1) return m_active[i].rgb;
        end
        return 3'b000;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = '{default: 0};
            m_active[i] = '{default: 0};
        end
    endtask

    task automatic set_cfg(input int idx, input bit en, input int x0, input int x1,
                           input int y0, input int y1, input bit [2:0] rgb);
        cfg_if.cfg_idx = 3'(idx);
        cfg_if.cfg_en  = en;
        cfg_if.cfg_x0  = 13'(x0);
        cfg_if.cfg_x1  = 13'(x1);
        cfg_if.cfg_y0  = 13'(y0);
        cfg_if.cfg_y1  = 13'(y1);
        cfg_if.cfg_rgb = rgb;
    endtask

    task automatic cfg_write(input int idx, input bit en, input int x0, input int x1,
                             input int y0, input int y1, input bit [2:0] rgb);
        bit accepted = 1'b0;
        set_cfg(idx, en, x0, x1, y0, y1, rgb);
        cfg_if.cfg_valid = 1'b1;
        for (int n = 0; n < 64 && !accepted; n++) begin
            if (cfg_if.cfg_ready) accepted = 1'b1;
            step();
        end
        cfg_if.cfg_valid = 1'b0;
        n_tests++;
        if (accepted !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_write idx%0d: accepted=%0b required 1", idx, accepted);
        end else begin
            m_shadow[idx] = '{en: en, x0: x0, x1: x1, y0: y0, y1: y1, rgb: rgb};
        end
    endtask

    // Streams one row segment; each cycle compares the output for the previous pixel.
    task automatic px_stream(input int h_lo, input int h_hi, input int v, input string name);
        bit [2:0] exp;
        bit [2:0] got;
        for (int h = h_lo; h <= h_hi + 1; h++) begin
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {red, green, blue};
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL %s h=%0d v=%0d: rgb=%03b required %03b", name, h - 1, v, got, exp);
                end
            end
            if (h <= h_hi) begin
                pix_h = 13'(h);
                pix_v = 13'(v);
                exp_q.push_back(model_rgb(h, v));
                step();
            end
        end
    endtask

    task automatic probe(input int h, input int v, input bit [2:0] exp_in, input string name);
        bit [2:0] exp;
        bit [2:0] got;
        pix_h = 13'(h);
        pix_v = 13'(v);
        exp_q.push_back(exp_in);
        step();
        exp = exp_q.pop_front();
        got = {red, green, blue};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (%0d,%0d): rgb=%03b required %03b", name, h, v, got, exp);
        end
    endtask

    task automatic commit_frame(input string tag);
        int lat = 0;
        pix_v = 13'd500;
        pix_h = 13'd0;
        cfg_if.commit_req = 1'b1;
        step();
        cfg_if.commit_req = 1'b0;
        n_tests++;
        if ({cfg_if.commit_busy, cfg_if.cfg_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s pending: busy,ready=%b%b required 10", tag, cfg_if.commit_busy, cfg_if.cfg_ready);
        end
        for (int n = 1; n <= 4; n++) begin
            pix_h = 13'(n * 300);
            step();
        end
        n_tests++;
        if ({cfg_if.commit_busy, cfg_if.cfg_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s pre_vblank: busy,ready=%b%b required 10", tag, cfg_if.commit_busy, cfg_if.cfg_ready);
        end
        pix_v = 13'd1024;
        pix_h = 13'd0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            step();
            pix_h = pix_h + 13'd1;
            if (cfg_if.commit_done) lat = k;
        end
        n_tests++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL %s done_latency: %0d cycles required 9", tag, lat);
        end
        m_active = m_shadow;
        step();
        n_tests++;
        if ({cfg_if.commit_done, cfg_if.commit_busy, cfg_if.cfg_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL %s after_done: done,busy,ready=%b%b%b required 001", tag,
                     cfg_if.commit_done, cfg_if.commit_busy, cfg_if.cfg_ready);
        end
    endtask

    task automatic test_reset();
        // A full-screen write offered during reset must be dropped.
        set_cfg(1, 1'b1, 0, 1280, 0, 1024, 3'b111);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.commit_req = 1'b0;
        step();
        step();
        n_tests++;
        if ({cfg_if.cfg_ready, cfg_if.commit_busy, cfg_if.commit_done, red, green, blue} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_state: ready,busy,done,rgb=%b%b%b%b%b%b required 100000",
                     cfg_if.cfg_ready, cfg_if.commit_busy, cfg_if.commit_done, red, green, blue);
        end
        cfg_if.cfg_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_no_commit();
        cfg_write(0, 1'b1, 100, 200, 50, 60, 3'b100);
        px_stream(95, 205, 55, "no_commit_row55");
        probe(150, 50, 3'b000, "no_commit_inside");
    endtask

    task automatic test_commit();
        commit_frame("commit1");
        probe(150, 55, 3'b100, "commit_inside");
        probe(200, 55, 3'b000, "commit_x1_excl");
        probe(100, 59, 3'b100, "commit_corner");
        px_stream(95, 205, 50, "commit_row50");
        px_stream(95, 205, 59, "commit_row59");
        px_stream(98, 102, 49, "commit_row49");
        px_stream(98, 102, 60, "commit_row60");
    endtask

    task automatic test_overlap();
        cfg_write(2, 1'b1, 0, 400, 0, 400, 3'b010);
        cfg_write(5, 1'b1, 0, 400, 0, 400, 3'b001);
        commit_frame("overlap");
        probe(300, 300, 3'b010, "overlap_idx2_wins");
        probe(150, 55, 3'b100, "overlap_idx0_wins");
        cfg_write(2, 1'b0, 0, 400, 0, 400, 3'b010);
        commit_frame("overlap_dis");
        probe(300, 300, 3'b001, "overlap_idx5_after");
        px_stream(395, 405, 399, "overlap_edge");
    endtask

    task automatic test_boundary();
        cfg_write(3, 1'b1, 300, 300, 500, 600, 3'b111);
        cfg_write(4, 1'b1, 1200, 1400, 1000, 1030, 3'b011);
        commit_frame("boundary");
        px_stream(295, 305, 550, "degenerate_row");
        probe(300, 550, 3'b000, "degenerate_x0");
        px_stream(1275, 1285, 1023, "right_edge_row");
        probe(1279, 1023, 3'b011, "last_visible");
        probe(1280, 1023, 3'b000, "first_hblank");
        probe(1300, 1010, 3'b000, "x1_beyond_active");
        probe(1279, 1024, 3'b000, "first_vblank");
    endtask

    task automatic test_handshake();
        bit early  = 1'b0;
        bit rdy_at = 1'b0;
        int lat    = 0;
        int extra  = 0;
        pix_v = 13'd500;
        pix_h = 13'd0;
        cfg_if.commit_req = 1'b1;
        step();
        cfg_if.commit_req = 1'b0;
        set_cfg(6, 1'b1, 600, 700, 600, 700, 3'b110);
        cfg_if.cfg_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            if (cfg_if.cfg_ready) early = 1'b1;
            step();
        end
        pix_v = 13'd1024;
        pix_h = 13'd0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            if (cfg_if.cfg_ready) early = 1'b1;
            step();
            pix_h = pix_h + 13'd1;
            cfg_if.commit_req = (k == 3);
            if (cfg_if.commit_done) begin
                lat    = k;
                rdy_at = cfg_if.cfg_ready;
            end
        end
        cfg_if.commit_req = 1'b0;
        n_tests++;
        if (early !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_ready_early: ready seen=%0b required 0", early);
        end
        n_tests++;
        if (lat !== 9 || rdy_at !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_done: latency=%0d ready=%0b required 9/1", lat, rdy_at);
        end
        m_active = m_shadow;
        step();
        cfg_if.cfg_valid = 1'b0;
        m_shadow[6] = '{en: 1'b1, x0: 600, x1: 700, y0: 600, y1: 700, rgb: 3'b110};
        for (int n = 0; n < 20; n++) begin
            step();
            if (cfg_if.commit_done) extra++;
        end
        n_tests++;
        if (extra !== 0 || cfg_if.commit_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_second_req: extra_done=%0d busy=%0b required 0/0", extra, cfg_if.commit_busy);
        end
        probe(650, 650, 3'b000, "hs_shadow_frozen");
        commit_frame("hs_recommit");
        probe(650, 650, 3'b110, "hs_write_landed");
    endtask

    task automatic test_reset_mid_copy();
        int extra = 0;
        pix_v = 13'd500;
        pix_h = 13'd0;
        cfg_if.commit_req = 1'b1;
        step();
        cfg_if.commit_req = 1'b0;
        pix_v = 13'd1024;
        for (int k = 1; k <= 4; k++) begin
            step();
            pix_h = pix_h + 13'd1;
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int n = 0; n < 15; n++) begin
            step();
            if (cfg_if.commit_done) extra++;
        end
        n_tests++;
        if (extra !== 0 || {cfg_if.commit_busy, cfg_if.cfg_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_copy_abort: done_pulses=%0d busy,ready=%b%b required 0/01",
                     extra, cfg_if.commit_busy, cfg_if.cfg_ready);
        end
        clear_model();
        px_stream(95, 105, 55, "rst_row55");
        probe(300, 300, 3'b000, "rst_active_cleared");
        commit_frame("rst_recommit");
        probe(650, 650, 3'b000, "rst_shadow_cleared");
        probe(150, 55, 3'b000, "rst_idx0_cleared");
    endtask

    initial begin
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.commit_req = 1'b0;
        set_cfg(0, 1'b0, 0, 0, 0, 0, 3'b000);
        clear_model();
        step();
        test_reset();
        test_no_commit();
        test_commit();
        test_overlap();
        test_boundary();
        test_handshake();
        test_reset_mid_copy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
